// File: rtl/ecc_pkg.sv
// Shared SEC-DED helpers: the check-bit width and data-to-position mapping for the
// extended Hamming layout, plus the decode status encoding.
package ecc_pkg;

  typedef enum logic [1:0] {ECC_CLEAN, ECC_SEC, ECC_DED} ecc_status_t;

  // Smallest k with 2^k >= data_w + k + 1.
  function automatic int chk_w(input int data_w);
    int k;
    k = 0;
    while ((1 << k) < data_w + k + 1) k++;
    return k;
  endfunction

  // Data bit i lands on the (i+1)-th position that is not a power of two.
  function automatic int data_pos(input int i);
    int pos;
    int seen;
    pos  = 0;
    seen = -1;
    while (seen < i) begin
      pos++;
      if ((pos & (pos - 1)) != 0) seen++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity mismatch for one received codeword.
module secded_syndrome
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W  = chk_w(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [CHK_W:0]    i_parity,
  output logic [CHK_W-1:0]  o_syn,
  output logic              o_ovr
);

  logic [CHK_W-1:0] w_pos [DATA_W];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
    assign w_pos[gi] = CHK_W'(data_pos(gi));
  end

  always_comb begin
    o_syn = '0;
    for (int k = 0; k < CHK_W; k++) begin
      if (i_parity[k]) o_syn = o_syn ^ (CHK_W'(1) << k);
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (i_data[i]) o_syn = o_syn ^ w_pos[i];
    end
    o_ovr = ^{i_parity, i_data};
  end

endmodule

// File: rtl/secded_pipe_decoder.sv
// Two-stage SEC-DED decoder with valid/ready flow control and saturating error counters.
// Optional error injection at the input is enabled by defining ECC_ERR_INJECT_EN.
module secded_pipe_decoder
  import ecc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHK_W   = ecc_pkg::chk_w(DATA_W),
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CHK_W:0]     in_parity,
`ifdef ECC_ERR_INJECT_EN
  input  logic               inj_en,
  input  logic [DATA_W+CHK_W:0] inj_mask,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CHK_W:0]     out_parity,
  output logic               single_error,
  output logic               double_error,
  output logic [CHK_W-1:0]   error_location,
  output logic [COUNT_W-1:0] sec_count,
  output logic [COUNT_W-1:0] ded_count,
  input  logic               cnt_clr
);

  localparam int LAST   = DATA_W + CHK_W;
  localparam int WORD_W = DATA_W + CHK_W + 1;

  // Handshake: a beat moves on either side only when valid && ready; the whole
  // pipe advances together when the output slot is empty or being drained.
  logic              w_adv;
  logic [WORD_W-1:0] w_word;
  logic [CHK_W-1:0]  w_syn;
  logic              w_ovr;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic [CHK_W:0]    r_s1_parity;
  logic [CHK_W-1:0]  r_s1_syn;
  logic              r_s1_ovr;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CHK_W:0]    r_out_parity;
  logic              r_single;
  logic              r_double;
  logic [CHK_W-1:0]  r_loc;
  logic [COUNT_W-1:0] r_sec;
  logic [COUNT_W-1:0] r_ded;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

`ifdef ECC_ERR_INJECT_EN
  assign w_word = {in_parity, in_data} ^ (inj_en ? inj_mask : '0);
`else
  assign w_word = {in_parity, in_data};
`endif

  secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
    .i_data   (w_word[DATA_W-1:0]),
    .i_parity (w_word[WORD_W-1:DATA_W]),
    .o_syn    (w_syn),
    .o_ovr    (w_ovr)
  );

  logic [CHK_W-1:0] w_pos [DATA_W];
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
    assign w_pos[gi] = CHK_W'(data_pos(gi));
  end

  ecc_status_t       w_status;
  logic [DATA_W-1:0] w_cor_data;
  logic [CHK_W:0]    w_cor_par;
  logic [CHK_W-1:0]  w_loc;

  always_comb begin
    w_status   = ECC_CLEAN;
    w_cor_data = r_s1_data;
    w_cor_par  = r_s1_parity;
    w_loc      = '0;
    if (r_s1_ovr) begin
      // An odd error count pointing past the codeword can only be a multi-bit error.
      if (int'(r_s1_syn) > LAST) begin
        w_status = ECC_DED;
      end else begin
        w_status = ECC_SEC;
        w_loc    = r_s1_syn;
        if (r_s1_syn == '0) w_cor_par[CHK_W] = ~w_cor_par[CHK_W];
        for (int k = 0; k < CHK_W; k++) begin
          if (r_s1_syn == (CHK_W'(1) << k)) w_cor_par[k] = ~w_cor_par[k];
        end
        for (int i = 0; i < DATA_W; i++) begin
          if (r_s1_syn == w_pos[i]) w_cor_data[i] = ~w_cor_data[i];
        end
      end
    end else if (r_s1_syn != '0) begin
      w_status = ECC_DED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_parity  <= '0;
      r_s1_syn     <= '0;
      r_s1_ovr     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_parity <= '0;
      r_single     <= 1'b0;
      r_double     <= 1'b0;
      r_loc        <= '0;
    end else if (w_adv) begin
      r_s1_valid   <= in_valid;
      r_s1_data    <= w_word[DATA_W-1:0];
      r_s1_parity  <= w_word[WORD_W-1:DATA_W];
      r_s1_syn     <= w_syn;
      r_s1_ovr     <= w_ovr;
      r_out_valid  <= r_s1_valid;
      r_out_data   <= w_cor_data;
      r_out_parity <= w_cor_par;
      r_single     <= r_s1_valid && (w_status == ECC_SEC);
      r_double     <= r_s1_valid && (w_status == ECC_DED);
      r_loc        <= r_s1_valid ? w_loc : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec <= '0;
      r_ded <= '0;
    end else if (cnt_clr) begin
      r_sec <= '0;
      r_ded <= '0;
    end else if (r_out_valid && out_ready) begin
      if (r_single && (r_sec != '1)) r_sec <= r_sec + COUNT_W'(1);
      if (r_double && (r_ded != '1)) r_ded <= r_ded + COUNT_W'(1);
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_parity     = r_out_parity;
  assign single_error   = r_single;
  assign double_error   = r_double;
  assign error_location = r_loc;
  assign sec_count      = r_sec;
  assign ded_count      = r_ded;

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Directed bench for secded_pipe_decoder: vector table, stalled stream, reset flush,
// counter saturation/clear, and injection when ECC_ERR_INJECT_EN is defined.
module tb_secded_pipe_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [6:0]  in_parity;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [6:0]  out_parity;
  logic        single_error;
  logic        double_error;
  logic [5:0]  error_location;
  logic [15:0] sec_count;
  logic [15:0] ded_count;
  logic        cnt_clr;
`ifdef ECC_ERR_INJECT_EN
  logic        inj_en;
  logic [38:0] inj_mask;
`endif

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_data;
  logic [6:0]  sat_out_parity;
  logic        sat_single;
  logic        sat_double;
  logic [5:0]  sat_loc;
  logic [1:0]  sat_sec;
  logic [1:0]  sat_ded;

  secded_pipe_decoder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_parity(in_parity),
`ifdef ECC_ERR_INJECT_EN
    .inj_en(inj_en), .inj_mask(inj_mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .single_error(single_error), .double_error(double_error),
    .error_location(error_location), .sec_count(sec_count), .ded_count(ded_count),
    .cnt_clr(cnt_clr)
  );

  secded_pipe_decoder #(.COUNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_data(in_data), .in_parity(in_parity),
`ifdef ECC_ERR_INJECT_EN
    .inj_en(inj_en), .inj_mask(inj_mask),
`endif
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_parity(sat_out_parity), .single_error(sat_single), .double_error(sat_double),
    .error_location(sat_loc), .sec_count(sat_sec), .ded_count(sat_ded),
    .cnt_clr(cnt_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [6:0]  par;
    logic [31:0] exp_data;
    logic [6:0]  exp_par;
    logic        exp_se;
    logic        exp_de;
    logic [5:0]  exp_loc;
  } vec_t;

  vec_t vecs[12];

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] m_sec, m_ded;
  logic [1:0]  m_sec_sat, m_ded_sat;
  logic [33:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_beat(input logic se, input logic de);
    if (se) begin
      m_sec++;
      if (m_sec_sat != 2'b11) m_sec_sat++;
    end
    if (de) begin
      m_ded++;
      if (m_ded_sat != 2'b11) m_ded_sat++;
    end
  endtask

  task automatic check_counts(input string nm);
    chk({nm, "_sec"}, 64'(sec_count), 64'(m_sec));
    chk({nm, "_ded"}, 64'(ded_count), 64'(m_ded));
    chk({nm, "_sat_sec"}, 64'(sat_sec), 64'(m_sec_sat));
    chk({nm, "_sat_ded"}, 64'(sat_ded), 64'(m_ded_sat));
  endtask

  // driver: one word through an empty pipe, checking latency and results
  task automatic send_check(input vec_t v, input int id);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = v.data;
    in_parity = v.par;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", id), 64'(lat), 64'd2);
    chk($sformatf("v%0d_data", id), 64'(out_data), 64'(v.exp_data));
    chk($sformatf("v%0d_parity", id), 64'(out_parity), 64'(v.exp_par));
    chk($sformatf("v%0d_single", id), 64'(single_error), 64'(v.exp_se));
    chk($sformatf("v%0d_double", id), 64'(double_error), 64'(v.exp_de));
    chk($sformatf("v%0d_loc", id), 64'(error_location), 64'(v.exp_loc));
    model_beat(v.exp_se, v.exp_de);
    @(negedge clk);
    check_counts($sformatf("v%0d_cnt", id));
  endtask

  task automatic run_stream();
    logic [31:0] d[4];
    logic [6:0]  p[4];
    logic [33:0] held, exp, act;
    logic        hold;
    int idx, got, extra;
    d = '{32'h1, 32'h1, 32'h2, 32'hE000_0000};
    p = '{7'h00, 7'h43, 7'h45, 7'h00};
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    exp_q.push_back({1'b0, 1'b0, 32'h1});
    exp_q.push_back({1'b0, 1'b0, 32'h2});
    exp_q.push_back({1'b0, 1'b1, 32'hE000_0000});
    idx = 0; got = 0; hold = 1'b0; held = '0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_data   = d[idx];
        in_parity = p[idx];
      end
      #1;
      act = {single_error, double_error, out_data};
      if (c >= 3 && c <= 5) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (hold) chk("stall_stable", 64'(act), 64'(held));
      hold = out_valid && !out_ready;
      held = act;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", 64'(got), 64'd4);
        end else begin
          exp = exp_q.pop_front();
          chk($sformatf("stream_w%0d", got), 64'(act), 64'(exp));
          model_beat(exp[33], exp[32]);
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_got", 64'(got), 64'd4);
    chk("stream_left", 64'(exp_q.size()), 64'd0);
    check_counts("stream_cnt");
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream_no_dup", 64'(extra), 64'd0);
  endtask

  initial begin
    int extra;
    vecs[0]  = '{32'h0,         7'h00, 32'h0,         7'h00, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{32'h1,         7'h00, 32'h0,         7'h00, 1'b1, 1'b0, 6'd3};
    vecs[2]  = '{32'h0,         7'h01, 32'h0,         7'h00, 1'b1, 1'b0, 6'd1};
    vecs[3]  = '{32'h0,         7'h40, 32'h0,         7'h00, 1'b1, 1'b0, 6'd0};
    vecs[4]  = '{32'h3,         7'h00, 32'h3,         7'h00, 1'b0, 1'b1, 6'd0};
    vecs[5]  = '{32'h1,         7'h43, 32'h1,         7'h43, 1'b0, 1'b0, 6'd0};
    vecs[6]  = '{32'h1,         7'h47, 32'h1,         7'h43, 1'b1, 1'b0, 6'd4};
    vecs[7]  = '{32'h8000_0000, 7'h00, 32'h0,         7'h00, 1'b1, 1'b0, 6'd38};
    vecs[8]  = '{32'hE000_0000, 7'h00, 32'hE000_0000, 7'h00, 1'b0, 1'b1, 6'd0};
    vecs[9]  = '{32'h0,         7'h03, 32'h0,         7'h03, 1'b0, 1'b1, 6'd0};
    vecs[10] = '{32'h2,         7'h45, 32'h2,         7'h45, 1'b0, 1'b0, 6'd0};
    vecs[11] = '{32'h2,         7'h05, 32'h2,         7'h45, 1'b1, 1'b0, 6'd0};

    m_sec = '0; m_ded = '0; m_sec_sat = '0; m_ded_sat = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
`ifdef ECC_ERR_INJECT_EN
    inj_en = 1'b0; inj_mask = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_flags", 64'({single_error, double_error, error_location}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    check_counts("rst_cnt");

    for (int i = 0; i < 12; i++) send_check(vecs[i], i);

    run_stream();

    // reset with both stages occupied
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1; in_parity = 7'h00;
    @(negedge clk);
    in_data = 32'h3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_data", 64'(out_data), 64'd0);
    m_sec = '0; m_ded = '0; m_sec_sat = '0; m_ded_sat = '0;
    check_counts("flush_cnt");
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("flush_discard", 64'(extra), 64'd0);

    // saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) send_check(vecs[1], 100 + i);
    chk("sat_sec_three", 64'(sat_sec), 64'd3);
    chk("sat_main_five", 64'(sec_count), 64'd5);

    // clear wins over a coincident error beat
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1; in_parity = 7'h00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_beat_valid", 64'(out_valid && single_error), 64'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    m_sec = '0; m_ded = '0; m_sec_sat = '0; m_ded_sat = '0;
    check_counts("clr_cnt");

`ifdef ECC_ERR_INJECT_EN
    inj_en = 1'b1; inj_mask = 39'h1;
    send_check('{32'h0, 7'h00, 32'h0, 7'h00, 1'b1, 1'b0, 6'd3}, 200);
    inj_en = 1'b0; inj_mask = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/secded_pipe_decoder.md
Name: secded_pipe_decoder

Overview:
- Parametrised, pipelined SEC-DED decoder: extended Hamming code with DATA_W data bits, Hamming check bits and one overall-parity bit.
- Corrects any single-bit error in data or check bits and flags, without correcting, any double-bit error.
- Sits on the memory read-return path; valid/ready handshake on both sides; saturating error counters for scrub/health software.

Parameters:
- DATA_W, 32, data width (>=4).
- CHK_W, ecc_pkg::chk_w(DATA_W) (=6 for 32), Hamming check bits: smallest k with 2^k >= DATA_W+k+1.
- COUNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder accepts word.
- in_data  in  DATA_W  received data.
- in_parity  in  CHK_W+1  [k<CHK_W] = check bit at Hamming position 2^k; [CHK_W] = overall parity.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  corrected data.
- out_parity  out  CHK_W+1  corrected parity.
- single_error  out  1  one-bit error corrected (qualified by out_valid).
- double_error  out  1  uncorrectable error (qualified by out_valid).
- error_location  out  CHK_W  Hamming position corrected; 0 when clean, when double, or when the overall bit was the error.
- sec_count  out  COUNT_W  saturating count of single errors.
- ded_count  out  COUNT_W  saturating count of double errors.
- cnt_clr  in  1  synchronous counter clear.

Behaviour:
- Code layout: positions 1..DATA_W+CHK_W. Powers of two hold check bits. Data bits fill the remaining positions in ascending order, bit 0 first (bit0->pos3, bit1->pos5, bit2->pos6, bit3->pos7, ...). Overall bit = XOR of all data and check bits.
- Syndrome s: XOR of positions of all set bits, including check bits. Overall mismatch o: XOR of all received bits including the overall bit.
- Classification:
  - s=0, o=0: clean.
  - o=1: single error. Flip the bit at position s; s=0 means the overall bit flips.
  - s!=0, o=0: double error. Pass data and parity through unmodified.
  - s beyond the last valid position with o=1: classify as double.
- Pipeline: stage 1 registers the word, s and o. Stage 2 registers the corrected word and flags. Latency is exactly 2 cycles from the accepting edge when out_ready stays high.
- Stall: adv = !out_valid || out_ready; in_ready = adv. Both stages move together when adv=1 and hold otherwise. A bubble in stage 1 clears stage 2's valid on advance.
- Transfers occur only when valid && ready. Outputs stay stable while out_valid && !out_ready.
- Counters increment once per accepted output beat (out_valid && out_ready) with the matching flag. They saturate at all-ones. cnt_clr takes priority over a same-cycle increment.
- Reset: out_valid=0, internal valids=0, out_data=0, out_parity=0, flags=0, error_location=0, counters=0. in_ready=1 after reset. Reset mid-stream discards in-flight words.

Optional Feature:
- Macro ECC_ERR_INJECT_EN.
- When defined, adds two ports:
  - inj_en  in  1
  - inj_mask  in  DATA_W+CHK_W+1
- When inj_en=1, {in_parity,in_data} is XORed with inj_mask at acceptance, before syndrome compute. This is used for field testing of the error paths.
- When undefined, neither port exists and the path is identical to inj_en=0.

Decomposition:
- Package ecc_pkg holds:
  - function chk_w(data_w);
  - function data_pos(i), mapping data bit i to its Hamming position;
  - enum typedef ecc_status_t {ECC_CLEAN, ECC_SEC, ECC_DED}.
- One natural sub-module: secded_syndrome (combinational s/o generator), instanced in stage 1.

Test Plan:
1. data=32'h0, parity=7'h00 -> after 2 cycles: out_data=0, single_error=0, double_error=0, error_location=0.
2. data=32'h1, parity=7'h00 -> out_data=0, single_error=1, error_location=3, sec_count=1.
3. data=32'h0, parity=7'h01 -> out_parity=7'h00, single_error=1, error_location=1. Then parity=7'h40 -> single_error=1, error_location=0.
4. data=32'h3, parity=7'h00 -> double_error=1, out_data=32'h3 unmodified, error_location=0, ded_count=1.
5. Back-to-back stream of 4 words with out_ready low for cycles 3-5 -> in_ready low during stall, no word lost or duplicated, outputs stable while stalled. Then COUNT_W=2 with 5 single errors -> sec_count=3. cnt_clr asserted with an error beat -> count 0.
6. Assert rst with both stages full -> out_valid=0 next cycle, counters 0. With ECC_ERR_INJECT_EN: inj_mask bit 0 set on clean word 32'h0 -> single_error=1, error_location=3.
